// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key map and index helper for the 4x4 keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } state_t;

  // Indexed [row][col]; row = rows_sync bit, col = cols bit.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Lowest set bit wins, so a multi-row press resolves to the lowest row.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_dwell_counter.sv
// rtl/keypad_scanner_dwell_counter.sv - saturating cycle counter; done while holding MAX-1
module dwell_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scan with press/release debounce and one pulse per press
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_sync,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  state_t     state_q, state_d;
  logic [3:0] cols_q, cols_d;
  logic [3:0] key_q, key_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;

  logic       dwell_done, db_done;
  logic       row_hit;
  logic [3:0] cols_next;

  assign row_hit   = rows_sync[row_q];
  assign cols_next = {cols_q[2:0], cols_q[3]};

  // Column dwell only runs while scanning, so any return to SCAN starts a fresh column.
  dwell_counter #(.MAX(SCAN_CYCLES)) u_dwell (
    .clk   (clk),
    .rst_n (reset),
    .clear ((state_q != SCAN) || dwell_done),
    .en    (state_q == SCAN),
    .done  (dwell_done)
  );

  dwell_counter #(.MAX(DEBOUNCE_CYCLES)) u_debounce (
    .clk   (clk),
    .rst_n (reset),
    .clear ((state_q == SCAN) || (state_q == HELD)),
    .en    (1'b1),
    .done  (db_done)
  );

  always_comb begin
    state_d     = state_q;
    cols_d      = cols_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    row_d       = row_q;
    col_d       = col_q;
    case (state_q)
      SCAN: begin
        if (dwell_done) begin
          if (|rows_sync) begin
            row_d   = onehot_to_idx(rows_sync);
            col_d   = onehot_to_idx(cols_q);
            state_d = DB_PRESS;
          end else begin
            cols_d = cols_next;
          end
        end
      end
      DB_PRESS: begin
        if (!row_hit) begin
          state_d = SCAN;
          cols_d  = cols_next;
        end else if (db_done) begin
          key_d       = KEYMAP[row_q][col_q];
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
        end
      end
      HELD: begin
        if (!row_hit) state_d = DB_RELEASE;
      end
      DB_RELEASE: begin
        if (row_hit) begin
          state_d = HELD;
        end else if (db_done) begin
          key_held_d = 1'b0;
          state_d    = SCAN;
          cols_d     = cols_next;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      cols_q      <= 4'b0001;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      cols_q      <= cols_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      row_q       <= row_d;
      col_q       <= col_d;
    end
  end

  assign cols      = cols_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
